sklansky_adder_pipe: RTL
========================

SKLANSKY_ADDER_PIPE -- requirements
Module: sklansky_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; legal values are powers of two, 8..64.
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline register count (latency); legal range is 1..log2(WIDTH)+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 SHALL have ports A and B, inputs, WIDTH bits each: operands.
REQ-008 SHALL have port Cin, input, 1 bit: carry-in, used when Sub=0.
REQ-009 SHALL have port Sub, input, 1 bit: 1 selects A-B.
REQ-010 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port Sum, output, WIDTH bits: result.
REQ-013 SHALL have port Cout, output, 1 bit: carry out of the MSB.
REQ-014 SHALL have port Ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 SHALL have port Zero, output, 1 bit: asserted when Sum==0.

Function
REQ-016 SHALL compute the effective operand Beff = Sub ? ~B : B and the carry-in c0 = Sub ? 1 : Cin (Cin ignored when Sub=1).
REQ-017 SHALL form bitwise P=A^Beff and G=A&Beff, then carries via a Sklansky (divide-and-conquer) prefix tree of log2(WIDTH) levels with c0 folded into bit 0's generate; ripple carry chains are forbidden.
REQ-018 SHALL set Sum[i]=P[i]^c[i] and Cout=carry out of bit WIDTH-1, so {Cout,Sum} is exactly A+Beff+c0 modulo 2^(WIDTH+1).
REQ-019 SHALL set Ovf=c[WIDTH-1]^Cout and Zero=(Sum==0).
REQ-020 SHALL place STAGES register boundaries: the final boundary drives the outputs, and the others are spread as evenly as possible across the prefix levels; results SHALL be bit-identical for every legal STAGES value.
REQ-021 SHALL define advance = !out_valid || out_ready and drive in_ready = advance, combinationally, with no dependence on in_valid.
REQ-022 SHALL, when advance=1, shift every stage (valid bit plus data) forward one position; when advance=0, hold all stages unchanged.
REQ-023 SHALL, on a beat accepted at edge t (in_valid && in_ready) with advance held continuously, present it with out_valid=1 in the cycle after edge t+STAGES-1 (latency STAGES).
REQ-024 SHALL sustain throughput of 1 beat/cycle while out_ready=1.
REQ-025 SHALL hold Sum, Cout, Ovf and Zero stable while out_valid=1 and out_ready=0.
REQ-026 SHALL keep data registers of invalid stages don't-care, but the Sum/Cout/Ovf/Zero outputs SHALL read 0 whenever out_valid=0.
REQ-027 SHALL deliver beats in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.

Reset
REQ-028 SHALL, while rst=1 at an edge, clear all stage valid bits and output registers, so that next cycle out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0 and in_ready=1.
REQ-029 SHALL let rst take priority over advance, discarding in-flight beats mid-operation; no beat offered during a reset cycle is captured.

Verification
REQ-030 SHALL pass, for WIDTH=8, STAGES=1, Sub=0, Cin=1: A=0xFF, B=0x00 -> Sum=0x00, Cout=1, Zero=1, Ovf=0 one cycle later.
REQ-031 SHALL pass, for WIDTH=32, Sub=1: A=0x80000000, B=1 -> Sum=0x7FFFFFFF, Cout=1, Ovf=1; A=5, B=7 -> Sum=0xFFFFFFFE, Cout=0, Ovf=0.
REQ-032 SHALL pass a streaming test with WIDTH=16, STAGES=3, 100 back-to-back beats and out_ready=1: first out_valid 3 cycles after the first accept, then one result per cycle matching the model.
REQ-033 SHALL pass a backpressure test with out_ready toggled pseudo-randomly and in_valid random: outputs stay stable while stalled, and the in-order sequence matches the reference sum with no drops or duplicates.
REQ-034 SHALL pass a reset test asserting rst for 1 cycle with 3 beats in flight: out_valid=0 on the next cycle, none of those 3 results ever emerges, and the next accepted beat appears after STAGES cycles.
REQ-035 SHALL pass an exhaustive test for WIDTH=8 across all STAGES values, with all A, B, Cin and Sub combinations matching {Cout,Sum}, Ovf and Zero.

Source files
------------

// File: rtl/sklansky_adder_pipe.sv
// Pipelined add/subtract unit built on a Sklansky parallel-prefix carry tree.
// STAGES register boundaries: the last one drives the outputs, the rest sit between prefix levels.
module sklansky_adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int LEVELS = $clog2(WIDTH);
   localparam int DW     = 3 * WIDTH + 1;

   // Internal boundary k lands after prefix level ceil(k*LEVELS/STAGES)-1.
   function automatic logic f_reg_after(input int lvl);
      logic r;
      r = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         if ((k * LEVELS + STAGES - 1) / STAGES - 1 == lvl) r = 1'b1;
      end
      return r;
   endfunction

   logic             w_advance;
   logic [WIDTH-1:0] w_beff;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_g0;
   logic             w_c0;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   assign w_advance = !r_out_valid || out_ready;
   assign in_ready  = w_advance;

   assign w_beff = Sub ? ~B : B;
   assign w_c0   = Sub | Cin;
   assign w_x    = A ^ w_beff;

   // Carry-in is folded into bit 0's generate so the tree yields true carries.
   always_comb begin
      w_g0    = A & w_beff;
      w_g0[0] = w_g0[0] | (w_x[0] & w_c0);
   end

   // Bus layout per level: {bitwise P, group P, group G, c0}
   logic [DW-1:0] w_bus [0:LEVELS];
   logic          w_vld [0:LEVELS];

   assign w_bus[0] = {w_x, w_x, w_g0, w_c0};
   assign w_vld[0] = in_valid;

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int SPAN = 1 << l;

      logic [WIDTH-1:0] w_x_l;
      logic [WIDTH-1:0] w_p_i;
      logic [WIDTH-1:0] w_g_i;
      logic [WIDTH-1:0] w_p_o;
      logic [WIDTH-1:0] w_g_o;
      logic             w_c_l;

      assign {w_x_l, w_p_i, w_g_i, w_c_l} = w_bus[l];

      always_comb begin
         int j;
         j     = 0;
         w_p_o = w_p_i;
         w_g_o = w_g_i;
         for (int i = 0; i < WIDTH; i++) begin
            if ((i & SPAN) != 0) begin
               j        = (i & ~(2 * SPAN - 1)) + SPAN - 1;
               w_g_o[i] = w_g_i[i] | (w_p_i[i] & w_g_i[j]);
               w_p_o[i] = w_p_i[i] & w_p_i[j];
            end
         end
      end

      if (f_reg_after(l)) begin : g_reg
         logic [DW-1:0] r_bus;
         logic          r_vld;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_vld <= 1'b0;
            end else if (w_advance) begin
               r_vld <= w_vld[l];
            end
         end

         always_ff @(posedge clk) begin
            if (w_advance) begin
               r_bus <= {w_x_l, w_p_o, w_g_o, w_c_l};
            end
         end

         assign w_bus[l+1] = r_bus;
         assign w_vld[l+1] = r_vld;
      end else begin : g_comb
         assign w_bus[l+1] = {w_x_l, w_p_o, w_g_o, w_c_l};
         assign w_vld[l+1] = w_vld[l];
      end
   end

   logic [WIDTH-1:0] w_xf;
   logic [WIDTH-1:0] w_gf;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_cf;

   assign w_xf    = w_bus[LEVELS][DW-1 -: WIDTH];
   assign w_gf    = w_bus[LEVELS][WIDTH:1];
   assign w_cf    = w_bus[LEVELS][0];
   assign w_carry = {w_gf[WIDTH-2:0], w_cf};
   assign w_sum   = w_xf ^ w_carry;

   // Output fields are forced to zero whenever no valid beat is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= w_vld[LEVELS];
         if (w_vld[LEVELS]) begin
            r_sum  <= w_sum;
            r_cout <= w_gf[WIDTH-1];
            r_ovf  <= w_carry[WIDTH-1] ^ w_gf[WIDTH-1];
            r_zero <= (w_sum == '0);
         end else begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign Sum       = r_sum;
   assign Cout      = r_cout;
   assign Ovf       = r_ovf;
   assign Zero      = r_zero;

endmodule
